// File: rtl/conv_encoder_tx_pkg.sv
// Shared types and helpers for the rate-1/2, K=3 convolutional encoder.
package conv_enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_BYTE,
    TAIL,
    DRAIN
  } state_t;

  localparam logic [2:0]  DEFAULT_G0 = 3'b111;
  localparam logic [2:0]  DEFAULT_G1 = 3'b101;
  localparam int unsigned K          = 3;
  localparam int unsigned TAIL_LEN   = K - 1;

  // r = {s1, s0, b}; each output bit is the parity of r under its generator mask.
  function automatic logic [1:0] conv_sym(input logic [1:0] st, input logic b,
                                          input logic [2:0] g0, input logic [2:0] g1);
    logic [2:0] r;
    r = {st, b};
    return {^(r & g0), ^(r & g1)};
  endfunction

endpackage

// File: rtl/conv_encoder_tx_if.sv
// Byte-in / symbol-out handshake bundle for conv_encoder_tx.
interface conv_encoder_tx_if #(
  parameter int unsigned CNT_W = 10
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic [2:0]       in_last_bits;
  logic             in_ready;
  logic [1:0]       sym_out;
  logic             sym_valid;
  logic             sym_ready;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] sym_count;

  modport slave (
    input  in_data, in_valid, in_last, in_last_bits, sym_ready,
    output in_ready, sym_out, sym_valid, busy, frame_done, sym_count
  );

  modport master (
    output in_data, in_valid, in_last, in_last_bits, sym_ready,
    input  in_ready, sym_out, sym_valid, busy, frame_done, sym_count
  );
endinterface

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 K=3 convolutional encoder: serialises frame bytes LSB first into
// 2-bit symbols and flushes the trellis to state 0 with zero tail bits.
module conv_encoder_tx
  import conv_enc_pkg::*;
#(
  parameter logic [2:0]  G0      = DEFAULT_G0,
  parameter logic [2:0]  G1      = DEFAULT_G1,
  parameter bit          TAIL_EN = 1'b1,
  parameter int unsigned CNT_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  conv_encoder_tx_if.slave  bus
);

  state_t           state;
  logic [1:0]       enc_state;
  logic [7:0]       shreg;
  logic [3:0]       bits_left;
  logic             last_q;
  logic             tail_cnt;
  logic [1:0]       sym_q;
  logic             sym_valid_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] cnt_q;

  logic       accept;
  logic       fire;
  logic       sym_acc;
  logic [3:0] load_bits;

  assign bus.in_ready   = !rst && (state == IDLE || state == WAIT_BYTE);
  assign bus.sym_out    = sym_q;
  assign bus.sym_valid  = sym_valid_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = frame_done_q;
  assign bus.sym_count  = cnt_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign fire      = !sym_valid_q || bus.sym_ready;
  assign sym_acc   = sym_valid_q && bus.sym_ready;
  assign load_bits = (bus.in_last && bus.in_last_bits != 3'd0) ? {1'b0, bus.in_last_bits} : 4'd8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      enc_state    <= '0;
      shreg        <= '0;
      bits_left    <= '0;
      last_q       <= 1'b0;
      tail_cnt     <= 1'b0;
      sym_q        <= '0;
      sym_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      // Retire an accepted symbol first; an emitting state below re-arms it.
      if (sym_acc) begin
        sym_valid_q <= 1'b0;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
      case (state)
        IDLE, WAIT_BYTE: begin
          if (accept) begin
            shreg     <= bus.in_data;
            bits_left <= load_bits;
            last_q    <= bus.in_last;
            state     <= SHIFT;
            if (state == IDLE) cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (fire) begin
            sym_q       <= conv_sym(enc_state, shreg[0], G0, G1);
            sym_valid_q <= 1'b1;
            enc_state   <= {enc_state[0], shreg[0]};
            shreg       <= {1'b0, shreg[7:1]};
            bits_left   <= bits_left - 1'b1;
            if (bits_left == 4'd1) begin
              if (!last_q) begin
                state <= WAIT_BYTE;
              end else if (TAIL_EN) begin
                state    <= TAIL;
                tail_cnt <= 1'b0;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        TAIL: begin
          if (fire) begin
            sym_q       <= conv_sym(enc_state, 1'b0, G0, G1);
            sym_valid_q <= 1'b1;
            enc_state   <= {enc_state[0], 1'b0};
            tail_cnt    <= 1'b1;
            if (tail_cnt == 1'(TAIL_LEN - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fire) begin
            sym_valid_q  <= 1'b0;
            frame_done_q <= 1'b1;
            enc_state    <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Scoreboard bench for conv_encoder_tx: tail-enabled and tail-disabled instances.
module tb_conv_encoder_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_encoder_tx_if #(.CNT_W(10)) ifa ();
  conv_encoder_tx_if #(.CNT_W(10)) ifb ();

  conv_encoder_tx #(.G0(3'b111), .G1(3'b101), .TAIL_EN(1'b1), .CNT_W(10)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  conv_encoder_tx #(.G0(3'b111), .G1(3'b101), .TAIL_EN(1'b0), .CNT_W(10)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  logic [7:0] drv_data;
  logic       drv_valid, drv_last, drv_ready, sel_b;
  logic [2:0] drv_lbits;

  assign ifa.in_data      = drv_data;
  assign ifb.in_data      = drv_data;
  assign ifa.in_last      = drv_last;
  assign ifb.in_last      = drv_last;
  assign ifa.in_last_bits = drv_lbits;
  assign ifb.in_last_bits = drv_lbits;
  assign ifa.in_valid     = drv_valid & ~sel_b;
  assign ifb.in_valid     = drv_valid & sel_b;
  assign ifa.sym_ready    = drv_ready;
  assign ifb.sym_ready    = drv_ready;

  logic       obs_in_ready, obs_sym_valid, obs_busy, obs_frame_done;
  logic [1:0] obs_sym_out;
  logic [9:0] obs_sym_count;
  assign obs_in_ready   = sel_b ? ifb.in_ready   : ifa.in_ready;
  assign obs_sym_valid  = sel_b ? ifb.sym_valid  : ifa.sym_valid;
  assign obs_busy       = sel_b ? ifb.busy       : ifa.busy;
  assign obs_frame_done = sel_b ? ifb.frame_done : ifa.frame_done;
  assign obs_sym_out    = sel_b ? ifb.sym_out    : ifa.sym_out;
  assign obs_sym_count  = sel_b ? ifb.sym_count  : ifa.sym_count;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [1:0]  exp_q[$];
  logic [1:0]  obs_log[$];
  int unsigned run_q[$];
  logic [1:0]  mst;

  logic [7:0]  fr_data[4];
  int unsigned fr_n;
  logic [2:0]  fr_lbits;
  int unsigned ready_period;
  bit          hold_valid;

  logic [1:0] t1_tab[10] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};

  function automatic logic [1:0] ref_sym(input logic [1:0] st, input logic b);
    return {st[1] ^ st[0] ^ b, st[1] ^ b};
  endfunction

  task automatic push_byte(input logic [7:0] d, input int unsigned nbits, input bit last, input bit tail);
    logic b;
    for (int unsigned i = 0; i < nbits; i++) begin
      b = d[i];
      exp_q.push_back(ref_sym(mst, b));
      mst = {mst[0], b};
    end
    if (last) begin
      if (tail) begin
        for (int unsigned i = 0; i < 2; i++) begin
          exp_q.push_back(ref_sym(mst, 1'b0));
          mst = {mst[0], 1'b0};
        end
      end
      mst = 2'b00;
    end
  endtask

  // Drives fr_data[0..fr_n-1] as one frame and checks every emitted symbol.
  task automatic run_frame(input string name, input int unsigned total);
    int unsigned waited, cyc, pulses, post, nb, run;
    bit          last, held;
    logic [1:0]  held_val, e;
    exp_q.delete();
    obs_log.delete();
    run_q.delete();
    fork
      begin
        for (int unsigned i = 0; i < fr_n; i++) begin
          last = (i == fr_n - 1);
          nb   = (last && fr_lbits != 3'd0) ? int'(fr_lbits) : 8;
          push_byte(fr_data[i], nb, last, !sel_b);
          drv_data  = fr_data[i];
          drv_last  = last;
          drv_lbits = last ? fr_lbits : 3'd5;
          drv_valid = 1'b1;
          waited = 0;
          while (!obs_in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
          end
          checks++;
          if (waited >= 300) begin
            failures++;
            $display("FAIL %s in_ready_timeout byte=%0d got=0 exp=1", name, i);
          end
          @(posedge clk);
          @(negedge clk);
        end
        if (hold_valid) begin
          waited = 0;
          while (obs_busy && waited < 300) begin
            @(negedge clk);
            waited++;
          end
        end
        drv_valid = 1'b0;
      end
      begin
        cyc = 0; pulses = 0; post = 0; held = 1'b0; held_val = '0; run = 0;
        while (cyc < 600 && post < 4) begin
          if (held) begin
            checks++;
            if (obs_sym_valid !== 1'b1 || obs_sym_out !== held_val) begin
              failures++;
              $display("FAIL %s stall_hold got=%b/%b exp=1/%b", name, obs_sym_valid, obs_sym_out, held_val);
            end
          end
          if (!obs_in_ready) run++;
          else if (run > 0) begin
            run_q.push_back(run);
            run = 0;
          end
          if (obs_frame_done) pulses++;
          drv_ready = ((cyc % ready_period) == 0);
          if (obs_sym_valid && drv_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL %s extra_symbol got=%b exp=none", name, obs_sym_out);
            end else begin
              e = exp_q.pop_front();
              if (obs_sym_out !== e) begin
                failures++;
                $display("FAIL %s sym[%0d] got=%b exp=%b", name, obs_log.size(), obs_sym_out, e);
              end
            end
            obs_log.push_back(obs_sym_out);
          end
          held = obs_sym_valid && !drv_ready;
          held_val = obs_sym_out;
          if (pulses > 0) post++;
          @(negedge clk);
          cyc++;
        end
        checks++;
        if (pulses != 1) begin
          failures++;
          $display("FAIL %s frame_done_pulses got=%0d exp=1", name, pulses);
        end
      end
    join
    drv_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || obs_log.size() != total) begin
      failures++;
      $display("FAIL %s symbol_total got=%0d exp=%0d", name, obs_log.size(), total);
    end
    checks++;
    if (obs_sym_count !== 10'(total)) begin
      failures++;
      $display("FAIL %s sym_count got=%0d exp=%0d", name, obs_sym_count, total);
    end
  endtask

  task automatic check_table(input string name);
    logic [1:0] t;
    for (int unsigned i = 0; i < 10; i++) begin
      t = t1_tab[i];
      checks++;
      if (i >= obs_log.size() || obs_log[i] !== t) begin
        failures++;
        $display("FAIL %s table[%0d] got=%b exp=%b", name, i, (i < obs_log.size()) ? obs_log[i] : 2'bxx, t);
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (obs_sym_valid !== 1'b0 || obs_sym_out !== 2'b00 || obs_busy !== 1'b0 ||
        obs_frame_done !== 1'b0 || obs_sym_count !== 10'd0 || obs_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s reset_outputs got=v%b s%b b%b fd%b c%0d r%b exp=v0 s00 b0 fd0 c0 r0",
               name, obs_sym_valid, obs_sym_out, obs_busy, obs_frame_done, obs_sym_count, obs_in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_in_ready !== 1'b1 || obs_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset idle_ready got=%b/%b exp=1/0", obs_in_ready, obs_busy);
    end
  endtask

  task automatic test_single_byte();
    fr_data[0] = 8'h2D; fr_n = 1; fr_lbits = 3'd0; ready_period = 1;
    run_frame("single_2d", 10);
    check_table("single_2d");
  endtask

  task automatic test_stall();
    fr_data[0] = 8'h2D; fr_n = 1; fr_lbits = 3'd0; ready_period = 3;
    run_frame("stall_2d", 10);
    check_table("stall_2d");
  endtask

  task automatic test_back_to_back();
    fr_data[0] = 8'hFF; fr_data[1] = 8'h00; fr_n = 2; fr_lbits = 3'd0; ready_period = 1;
    run_frame("ff_00", 18);
    checks++;
    if (obs_log.size() < 4 || {obs_log[0], obs_log[1], obs_log[2], obs_log[3]} !== 8'b11_01_10_10) begin
      failures++;
      $display("FAIL ff_00 first4 got=%p exp=11,01,10,10", obs_log);
    end
  endtask

  task automatic test_partial_no_tail();
    sel_b = 1'b1;
    @(negedge clk);
    fr_data[0] = 8'h05; fr_n = 1; fr_lbits = 3'd3; ready_period = 1;
    run_frame("partial_05", 3);
    checks++;
    if (obs_log.size() != 3 || {obs_log[0], obs_log[1], obs_log[2]} !== 6'b11_10_00) begin
      failures++;
      $display("FAIL partial_05 seq got=%p exp=11,10,00", obs_log);
    end
    sel_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int unsigned acc, w;
    drv_data = 8'h2D; drv_last = 1'b1; drv_lbits = 3'd0; drv_valid = 1'b1;
    w = 0;
    while (!obs_in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    acc = 0; w = 0;
    while (w < 50 && !(obs_sym_valid && acc == 3)) begin
      drv_ready = obs_sym_valid && acc < 3;
      if (drv_ready) acc++;
      @(negedge clk);
      w++;
    end
    drv_ready = 1'b0;
    checks++;
    if (w >= 50) begin
      failures++;
      $display("FAIL rst_mid reach_4th_stall got=%0d exp=3", acc);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    mst = 2'b00;
    @(negedge clk);
    fr_data[0] = 8'h2D; fr_n = 1; fr_lbits = 3'd0; ready_period = 1;
    run_frame("after_rst_2d", 10);
    check_table("after_rst_2d");
  endtask

  task automatic test_valid_hold();
    fr_data[0] = 8'hA5; fr_data[1] = 8'h3C; fr_n = 2; fr_lbits = 3'd0; ready_period = 1;
    hold_valid = 1'b1;
    run_frame("valid_hold", 18);
    hold_valid = 1'b0;
    checks++;
    if (run_q.size() != 2 || run_q[0] != 8 || run_q[1] != 11) begin
      failures++;
      $display("FAIL valid_hold in_ready_low_runs got=%p exp=8,11", run_q);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs_busy !== 1'b0) begin
      failures++;
      $display("FAIL valid_hold extra_frame busy got=%b exp=0", obs_busy);
    end
  endtask

  initial begin
    drv_data = '0; drv_valid = 1'b0; drv_last = 1'b0; drv_lbits = '0;
    drv_ready = 1'b0; sel_b = 1'b0; hold_valid = 1'b0; mst = 2'b00;
    test_reset();
    test_single_byte();
    test_stall();
    test_back_to_back();
    test_partial_no_tail();
    test_reset_mid_frame();
    test_valid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
